// File: rtl/buffer_wr_arbiter.sv
// ============================================================================
// Module      : buffer_wr_arbiter
// Description : Round-robin write-port arbiter in front of a single FIFO.
//               A grant lasts for at most BURST_LEN beats before it rotates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DWIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       buf_full,
    output logic                       buf_wr_en,
    output logic [DWIDTH-1:0]          buf_din,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       burst_done
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_CW-1:0]  c_LAST_BEAT = c_CW'(BURST_LEN - 1);
    localparam logic [c_IDW-1:0] c_LAST_ID   = c_IDW'(NUM_REQ - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_GRANT = 1'b1;

    logic [0:0]       r_state_q,    w_state_d;
    logic [c_IDW-1:0] r_grant_id_q, w_grant_id_d;
    logic [c_IDW-1:0] r_rr_ptr_q,   w_rr_ptr_d;
    logic [c_CW-1:0]  r_beat_cnt_q, w_beat_cnt_d;

    logic [c_IDW-1:0]  w_pick_id;
    logic              w_sel_valid;
    logic [DWIDTH-1:0] w_sel_data;
    logic              w_beat;
    logic              w_release;

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        int idx;
        w_pick_id = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(r_rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                w_pick_id = c_IDW'(idx);
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id_q == c_IDW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_data  = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // A dropped valid releases the grant even while the buffer is full.
    always_comb begin
        w_beat    = (r_state_q == c_S_GRANT) && w_sel_valid && !buf_full;
        w_release = (r_state_q == c_S_GRANT) &&
                    (!w_sel_valid || (w_beat && (r_beat_cnt_q == c_LAST_BEAT)));
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_id_d = r_grant_id_q;
        w_rr_ptr_d   = r_rr_ptr_q;
        w_beat_cnt_d = r_beat_cnt_q;
        req_ready    = '0;
        buf_wr_en    = 1'b0;
        buf_din      = '0;
        busy         = 1'b0;
        burst_done   = 1'b0;
        case (r_state_q)
            c_S_IDLE: begin
                if (|req_valid) begin
                    w_state_d    = c_S_GRANT;
                    w_grant_id_d = w_pick_id;
                    w_beat_cnt_d = '0;
                end
            end
            c_S_GRANT: begin
                busy       = 1'b1;
                buf_din    = w_sel_data;
                buf_wr_en  = w_beat;
                burst_done = w_release;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (r_grant_id_q == c_IDW'(i)) && !buf_full;
                end
                if (w_beat) begin
                    w_beat_cnt_d = r_beat_cnt_q + 1'b1;
                end
                if (w_release) begin
                    w_state_d  = c_S_IDLE;
                    w_rr_ptr_d = (r_grant_id_q == c_LAST_ID) ? '0 : r_grant_id_q + 1'b1;
                end
            end
            default: begin
                w_state_d = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= c_S_IDLE;
            r_grant_id_q <= '0;
            r_rr_ptr_q   <= '0;
            r_beat_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_id_q <= w_grant_id_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_beat_cnt_q <= w_beat_cnt_d;
        end
    end

    assign grant_id = r_grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_wr_arbiter.sv
// ============================================================================
// Module      : tb_buffer_wr_arbiter
// Description : Self-checking bench for buffer_wr_arbiter against a
//               transaction-level grant/beat model and per-requester scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          buf_full;
    logic          buf_wr_en;
    logic [DW-1:0] buf_din;
    logic [1:0]    grant_id;
    logic          busy;
    logic          burst_done;

    logic [N-1:0]    v1;
    logic [N*DW-1:0] d1;
    logic [N-1:0]    ready1;
    logic            full1;
    logic            wr1;
    logic [DW-1:0]   din1;
    logic [1:0]      grant1;
    logic            busy1;
    logic            done1;

    buffer_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .BURST_LEN(BL)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .buf_full(buf_full), .buf_wr_en(buf_wr_en),
        .buf_din(buf_din), .grant_id(grant_id), .busy(busy), .burst_done(burst_done)
    );

    buffer_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1),
        .req_ready(ready1), .buf_full(full1), .buf_wr_en(wr1),
        .buf_din(din1), .grant_id(grant1), .busy(busy1), .burst_done(done1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who holds the grant (-1 = nobody), beats served, last winner, next start.
    int m_grant, m_beats, m_last, m_rr;
    int seq  [N];
    int seen [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
    endtask

    task automatic model_reset();
        m_grant = -1;
        m_beats = 0;
        m_last  = 0;
        m_rr    = 0;
    endtask

    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_wr, e_busy, e_done, vg;
        logic [DW-1:0] e_din;
        int            id;
        @(negedge clk);
        e_ready = '0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_din = '0;
        if (!rst && m_grant >= 0) begin
            vg      = req_valid[m_grant];
            e_busy  = 1'b1;
            e_ready = buf_full ? '0 : N'(1 << m_grant);
            e_wr    = vg && !buf_full;
            e_din   = req_data[m_grant*DW +: DW];
            e_done  = !vg || (e_wr && m_beats == BL - 1);
        end
        chk("busy", 64'(busy), 64'(e_busy));
        chk("wr_en", 64'(buf_wr_en), 64'(e_wr));
        chk("ready", 64'(req_ready), 64'(e_ready));
        chk("din", 64'(buf_din), 64'(e_din));
        chk("done", 64'(burst_done), 64'(e_done));
        chk("grant_id", 64'(grant_id), 64'(m_last));
        if (buf_wr_en === 1'b1) begin
            id = int'(buf_din[15:12]);
            chk("sb_id_range", 64'(id < N), 64'(1));
            if (id < N) begin
                chk("sb_seq", 64'(buf_din[11:0]), 64'(12'(seen[id])));
                seen[id]++;
            end
        end
        @(posedge clk);
        if (!rst) begin
            if (m_grant < 0) begin
                for (int off = N - 1; off >= 0; off--) begin
                    if (req_valid[(m_rr + off) % N]) m_grant = (m_rr + off) % N;
                end
                if (m_grant >= 0) begin
                    m_last  = m_grant;
                    m_beats = 0;
                end
            end else begin
                if (e_wr) begin
                    m_beats++;
                    seq[m_grant]++;
                end
                if (e_done) begin
                    m_rr    = (m_grant + 1) % N;
                    m_grant = -1;
                end
            end
        end
        drive_data();
        #1;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            seen[i] = 0;
        end
        model_reset();
        rst = 1'b1; req_valid = '0; buf_full = 1'b0; drive_data();
        v1 = '0; full1 = 1'b0;
        d1 = {16'h0000, 16'h02A2, 16'h0000, 16'h00A0};
        step(); step();
        rst = 1'b0;

        // BURST_LEN=1 instance: 0101 alternates 0,2 with a write every other cycle.
        v1 = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bl1_busy", 64'(busy1), 64'(k % 2));
            chk("bl1_wr", 64'(wr1), 64'(k % 2));
            chk("bl1_done", 64'(done1), 64'(k % 2));
            if (k % 2 == 1) begin
                chk("bl1_grant", 64'(grant1), 64'((k % 4 == 1) ? 0 : 2));
                chk("bl1_din", 64'(din1), 64'((k % 4 == 1) ? 16'h00A0 : 16'h02A2));
            end
            @(posedge clk);
            #1;
        end
        v1 = '0;
        step(); step();

        // Single requester: back-to-back bursts with one idle cycle between.
        req_valid = 4'b0001;
        for (int k = 0; k < 22; k++) step();

        // All requesting: rotation 0,1,2,3,0.
        req_valid = 4'b1111;
        for (int k = 0; k < 45; k++) step();
        req_valid = '0;
        for (int k = 0; k < 10; k++) step();

        // Stall mid-burst with the buffer full.
        req_valid = 4'b0100;
        guard = 0;
        while (!(m_grant == 2 && m_beats == 3) && guard < 40) begin step(); guard++; end
        chk("sc3_reach", 64'(guard < 40), 64'(1));
        buf_full = 1'b1;
        for (int k = 0; k < 5; k++) step();
        buf_full = 1'b0;
        for (int k = 0; k < 8; k++) step();
        req_valid = '0;
        for (int k = 0; k < 10; k++) step();

        // Valid drop after two beats releases the grant; next goes to req 2.
        req_valid = 4'b0010;
        guard = 0;
        while (!(m_grant == 1 && m_beats == 2) && guard < 40) begin step(); guard++; end
        chk("sc4_reach", 64'(guard < 40), 64'(1));
        req_valid = 4'b0100;
        step(); step();
        chk("sc4_next", 64'(grant_id), 64'(2));
        for (int k = 0; k < 6; k++) step();

        // Asynchronous reset mid-burst.
        req_valid = 4'b1000;
        guard = 0;
        while (!(m_grant == 3 && m_beats == 4) && guard < 40) begin step(); guard++; end
        chk("sc5_reach", 64'(guard < 40), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wr", 64'(buf_wr_en), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(0));
        model_reset();
        step(); step();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) step();

        // Randomized traffic with sticky valids and random full.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
            end
            buf_full = ($urandom_range(0, 4) == 0);
            step();
        end
        req_valid = '0;
        buf_full  = 1'b0;
        for (int k = 0; k < 4; k++) step();

        for (int i = 0; i < N; i++) begin
            chk("sb_count", 64'(seen[i]), 64'(seq[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
